sl_bus_arbiter: RTL
===================

Name: sl_bus_arbiter

Overview:
- Round-robin arbiter for the shared tri-state slave output bus (sl_data / sl_overflow).
- Several message sources (basics, I2C, GOC, GPIO, MBus, UART interfaces) each raise a frame request. The arbiter grants exactly one at a time and holds the grant for a whole frame.
- Between owners it inserts a break-before-make gap. It forwards the downstream consumer's byte-latch strobe only while a frame is granted.
- It sits between the per-interface message FIFOs and the host-side serialiser.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of owner index; must satisfy 2^IDX_W >= NUM_REQ.
- WDOG_CYCLES, 1024, idle-latch cycles before a stalled owner is revoked (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sl_arb_request  in  NUM_REQ  per-requester frame request (the FIFO's out_frame_valid); high for the whole frame.
- sl_arb_grant  out  NUM_REQ  one-hot (or zero) grant; the owner drives sl_data while its bit is high.
- host_data_latch  in  1  consumer strobe: the byte currently on sl_data is taken this cycle.
- sl_data_latch  out  1  = host_data_latch & bus_busy; broadcast to all requesters.
- bus_busy  out  1  high while any grant bit is high.
- bus_owner  out  IDX_W  index of current/last owner.
- frame_done  out  1  one-cycle pulse when a granted frame ends normally.
- wdog_fault  out  1  one-cycle pulse on watchdog revoke (tied 0 without the feature).

Behaviour:
- All outputs are registered except sl_data_latch.
- Reset values: grant = 0, bus_busy = 0, bus_owner = NUM_REQ-1, frame_done = 0, wdog_fault = 0, state = IDLE, lockout mask = 0, watchdog counter = 0.
- Reset mid-frame drops the grant on the next edge; no gap is required.

State machine:
- IDLE: if any (request & ~lockout) bit is set, select the first set bit searching from bus_owner+1 upward, wrapping modulo NUM_REQ. Register grant one-hot, bus_owner = selected index, go to GRANT. The grant is visible one cycle after the request is sampled.
- GRANT: grant held constant. When the owner's request is low at a clock edge, clear grant, pulse frame_done, go to GAP. Requests from other requesters are ignored while in GRANT.
- GAP: exactly one cycle with grant = 0 (bus released, tri-state settles); always go to IDLE.
- Minimum spacing between two consecutive grants: 2 cycles with grant = 0 (GAP, then IDLE).

Fairness and edge cases:
- A requester that just finished has the lowest priority next round.
- With a single persistent requester, it is regranted every 3rd cycle boundary at most.
- A request that drops in the same cycle it is selected: the grant is still issued, then released in the next GRANT evaluation (a 1-cycle grant, then GAP).
- Simultaneous requests in IDLE: the round-robin order decides; only one grant bit is ever high (one-hot invariant).
- host_data_latch while not busy: ignored; sl_data_latch stays 0.
- Lockout mask: bit set only by a watchdog revoke; bit i clears when request[i] is sampled low.

Optional Feature:
- Macro SL_ARB_WATCHDOG_EN.
- When defined:
  - A counter clears on grant and on every host_data_latch, and increments each GRANT cycle otherwise.
  - On reaching WDOG_CYCLES: clear grant, pulse wdog_fault, set lockout bit for bus_owner, go to GAP. frame_done is not pulsed.
  - A locked-out requester is skipped until it drops its request.
- When undefined: no counter or lockout logic; wdog_fault is tied 0; grants are held indefinitely.

Test Plan:
- Reset, then request = 4'b0001 -> grant = 0001 one cycle later, bus_owner = 0. Drop request -> grant = 0 next cycle, frame_done pulse, regrant of no one.
- request = 4'b1111 held, each owner holds 3 cycles then drops/reraises -> grant order 0,1,2,3,0; exactly 2 zero-grant cycles between grants; never two bits high.
- Owner 2 granted, host_data_latch pulsed 5 times -> sl_data_latch pulses 5 times. Strobes while idle -> sl_data_latch stays 0.
- rst asserted mid-frame with grant = 0100 -> grant = 0 next edge, bus_owner = 3. After rst the first grant goes to the lowest active requester.
- With SL_ARB_WATCHDOG_EN, WDOG_CYCLES = 16, owner 1 holds request with no latches:
  - grant drops after 16 GRANT cycles, wdog_fault pulses, requester 3's pending request is granted next;
  - requester 1 is not regranted until its request drops for ≥1 cycle.
- Without the macro, same stimulus -> grant 0010 held 100+ cycles, wdog_fault stays 0.

Source files
------------

// File: rtl/sl_bus_arbiter.sv
// Round-robin owner arbiter for the shared slave output bus, with a break-before-make gap.
// Optional stalled-owner watchdog and lockout: define SL_ARB_WATCHDOG_EN.
module sl_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  input  logic               host_data_latch,
  output logic               sl_data_latch,
  output logic               bus_busy,
  output logic [IDX_W-1:0]   bus_owner,
  output logic               frame_done,
  output logic               wdog_fault
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] eligible;
  logic               owner_req;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  int                 cand;

`ifdef SL_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [NUM_REQ-1:0] lockout_reg;
  logic [WD_W-1:0]    wdog_cnt_reg;
  assign eligible = sl_arb_request & ~lockout_reg;
`else
  assign eligible   = sl_arb_request;
  // Constant low for every legal WDOG_CYCLES; the watchdog is absent in this build.
  assign wdog_fault = (WDOG_CYCLES < 1);
`endif

  // In GRANT the grant vector is the owner's one-hot, so this is the owner's request.
  assign owner_req     = |(sl_arb_request & sl_arb_grant);
  assign sl_data_latch = host_data_latch & bus_busy;

  // Search starts just after the last owner so it gets lowest priority next round.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = bus_owner;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(bus_owner) + k) % NUM_REQ;
      if (!sel_found && |(eligible & (NUM_REQ'(1) << cand))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sl_arb_grant <= '0;
      bus_busy     <= 1'b0;
      bus_owner    <= IDX_W'(NUM_REQ - 1);
      frame_done   <= 1'b0;
`ifdef SL_ARB_WATCHDOG_EN
      wdog_fault   <= 1'b0;
      lockout_reg  <= '0;
      wdog_cnt_reg <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef SL_ARB_WATCHDOG_EN
      wdog_fault  <= 1'b0;
      lockout_reg <= lockout_reg & sl_arb_request;
`endif
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            sl_arb_grant <= NUM_REQ'(1) << sel_idx;
            bus_busy     <= 1'b1;
            bus_owner    <= sel_idx;
            state_reg    <= GRANT;
`ifdef SL_ARB_WATCHDOG_EN
            wdog_cnt_reg <= '0;
`endif
          end
        end
        GRANT: begin
          if (!owner_req) begin
            sl_arb_grant <= '0;
            bus_busy     <= 1'b0;
            frame_done   <= 1'b1;
            state_reg    <= GAP;
          end
`ifdef SL_ARB_WATCHDOG_EN
          else if (host_data_latch) begin
            wdog_cnt_reg <= '0;
          end else if (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1)) begin
            sl_arb_grant <= '0;
            bus_busy     <= 1'b0;
            wdog_fault   <= 1'b1;
            lockout_reg  <= (lockout_reg & sl_arb_request) | sl_arb_grant;
            state_reg    <= GAP;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + WD_W'(1);
          end
`endif
        end
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
